// File: rtl/gravador_jogadas.sv
// gravador_jogadas: records a sequence of one-hot button presses into a
// 16x4 RAM. Recording starts on iniciar. It ends after limite+1 moves
// (pronto), on a timeout in ESPERA (erro_timeout), or on a multi-button
// press (erro_botao). The stored sequence is readable through a registered
// read port, so a later round can replay it instead of using the ROM.
//
// Ports:
//   clock             system clock, rising edge
//   reset             asynchronous, active-low
//   iniciar           start pulse; clears the move count and (re)starts recording
//   limite[3:0]       last move index, sampled with iniciar
//   botoes[3:0]       button levels, already synchronised
//   endereco_leitura  read address
//   dado_leitura      RAM[endereco_leitura], 1-cycle latency
//   gravando          high in ESPERA / REGISTRA / SOLTA
//   pronto            high in FIM
//   erro_timeout      high in ERRO when the cause was a timeout
//   erro_botao        high in ERRO when the cause was a non-one-hot press
//   num_jogadas[4:0]  number of moves written (0..16)
//   db_estado[3:0]    state encoding for debug
module gravador_jogadas #(
  parameter int unsigned TIMEOUT = 4000,
  parameter int unsigned DEPTH   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] limite,
  input  logic [3:0] botoes,
  input  logic [3:0] endereco_leitura,
  output logic [3:0] dado_leitura,
  output logic       gravando,
  output logic       pronto,
  output logic       erro_timeout,
  output logic       erro_botao,
  output logic [4:0] num_jogadas,
  output logic [3:0] db_estado
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    INICIAL  = 4'h0,
    ESPERA   = 4'h1,
    REGISTRA = 4'h2,
    SOLTA    = 4'h3,
    FIM      = 4'h4,
    ERRO     = 4'hE
  } estado_t;

  estado_t       estado, proxEstado;

  logic [3:0]    botoesAnt;
  logic [3:0]    botoesCapt;
  logic [3:0]    limiteReg;
  logic [4:0]    numJogadas;
  logic [CW-1:0] contador;
  logic          causaTimeout;
  logic          causaBotao;
  logic [3:0]    dadoLeitura;
  logic [3:0]    mem [DEPTH];

  logic pressao, umAtivo, fimTimeout, ultimaJogada;
  logic reiniciar, capturar, escrever, contar, setTimeout, setBotao;

  // A press is a rising transition from "no buttons" to "some buttons";
  // holding or changing buttons without release never counts again.
  assign pressao      = (botoesAnt == '0) && (botoes != '0);
  assign umAtivo      = $onehot(botoes);
  assign fimTimeout   = (contador == CW'(TIMEOUT - 1));
  assign ultimaJogada = (numJogadas == ({1'b0, limiteReg} + 5'd1));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proxEstado;
  end

  // Next state and datapath control. iniciar overrides every state, which
  // also suppresses the write of a move still sitting in REGISTRA.
  always_comb begin
    proxEstado = estado;
    reiniciar  = 1'b0;
    capturar   = 1'b0;
    escrever   = 1'b0;
    contar     = 1'b0;
    setTimeout = 1'b0;
    setBotao   = 1'b0;
    if (iniciar) begin
      proxEstado = ESPERA;
      reiniciar  = 1'b1;
    end else begin
      case (estado)
        ESPERA: begin
          // A press in the expiry cycle takes priority over the timeout.
          if (pressao) begin
            if (umAtivo) begin
              proxEstado = REGISTRA;
              capturar   = 1'b1;
            end else begin
              proxEstado = ERRO;
              setBotao   = 1'b1;
            end
          end else if (fimTimeout) begin
            proxEstado = ERRO;
            setTimeout = 1'b1;
          end else begin
            contar = 1'b1;
          end
        end
        REGISTRA: begin
          escrever   = 1'b1;
          proxEstado = SOLTA;
        end
        SOLTA: begin
          if (botoes == '0) begin
            if (ultimaJogada) proxEstado = FIM;
            else              proxEstado = ESPERA;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      botoesAnt    <= '0;
      botoesCapt   <= '0;
      limiteReg    <= '0;
      numJogadas   <= '0;
      contador     <= '0;
      causaTimeout <= 1'b0;
      causaBotao   <= 1'b0;
    end else begin
      botoesAnt <= botoes;
      if (reiniciar) begin
        limiteReg    <= limite;
        numJogadas   <= '0;
        contador     <= '0;
        causaTimeout <= 1'b0;
        causaBotao   <= 1'b0;
      end else begin
        if (capturar)   botoesCapt   <= botoes;
        if (contar)     contador     <= contador + CW'(1);
        if (escrever) begin
          numJogadas <= numJogadas + 5'd1;
          contador   <= '0;
        end
        if (setTimeout) causaTimeout <= 1'b1;
        if (setBotao)   causaBotao   <= 1'b1;
      end
    end
  end

  // Move RAM: contents survive reset.
  always_ff @(posedge clock) begin
    if (escrever) mem[numJogadas[3:0]] <= botoesCapt;
  end

  // Registered read; a same-cycle write to the same address returns old data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) dadoLeitura <= '0;
    else        dadoLeitura <= mem[endereco_leitura];
  end

  // Outputs
  always_comb begin
    gravando     = (estado == ESPERA) || (estado == REGISTRA) || (estado == SOLTA);
    pronto       = (estado == FIM);
    erro_timeout = (estado == ERRO) && causaTimeout;
    erro_botao   = (estado == ERRO) && causaBotao;
    num_jogadas  = numJogadas;
    db_estado    = estado;
    dado_leitura = dadoLeitura;
  end

endmodule

// File: tb/tb_gravador_jogadas.sv
// Directed + randomized bench for gravador_jogadas (TIMEOUT=20). A simple
// move-list model (stored values, count, limit) predicts outcomes.
module tb_gravador_jogadas;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [3:0] limite = '0;
  logic [3:0] botoes = '0;
  logic [3:0] endereco = '0;
  logic [3:0] dado;
  logic       gravando, pronto, erroTimeout, erroBotao;
  logic [4:0] numJogadas;
  logic [3:0] dbEstado;

  int unsigned nVec = 0;
  int unsigned nErr = 0;

  logic [3:0] refMem [16];
  bit         refValid [16];
  int         refCount = 0;
  int         refLimit = 0;

  gravador_jogadas #(.TIMEOUT(20)) dut (
    .clock            (clock),
    .reset            (reset),
    .iniciar          (iniciar),
    .limite           (limite),
    .botoes           (botoes),
    .endereco_leitura (endereco),
    .dado_leitura     (dado),
    .gravando         (gravando),
    .pronto           (pronto),
    .erro_timeout     (erroTimeout),
    .erro_botao       (erroBotao),
    .num_jogadas      (numJogadas),
    .db_estado        (dbEstado)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkFlags(input string tag, input int est, input bit grav, input bit pr,
                          input bit eT, input bit eB);
    chk({tag, ".estado"}, dbEstado, est);
    chk({tag, ".gravando"}, gravando, grav);
    chk({tag, ".pronto"}, pronto, pr);
    chk({tag, ".erroTimeout"}, erroTimeout, eT);
    chk({tag, ".erroBotao"}, erroBotao, eB);
  endtask

  task automatic iniciarT(input int lim);
    limite  = 4'(lim);
    iniciar = 1'b1;
    tick();
    iniciar  = 1'b0;
    refCount = 0;
    refLimit = lim;
    chkFlags("iniciar", 1, 1, 0, 0, 0);
    chk("iniciar.num", numJogadas, 0);
  endtask

  function automatic logic [3:0] randOneHot();
    logic [3:0] v;
    v = 4'(1 << $urandom_range(0, 3));
    return v;
  endfunction

  function automatic logic [3:0] randMulti();
    logic [3:0] v;
    do v = 4'($urandom_range(1, 15)); while ($countones(v) < 2);
    return v;
  endfunction

  // One valid move from ESPERA; buttons held 2+hold cycles, then released.
  task automatic pressMove(input logic [3:0] v, input int hold, input int gap);
    logic [3:0] a;
    a = 4'(refCount);
    botoes = v;
    tick();
    chk("press.registra", dbEstado, 2);
    endereco = a;
    tick();
    if (refValid[a]) chk("press.readOld", dado, refMem[a]);
    refMem[a]   = v;
    refValid[a] = 1'b1;
    refCount++;
    chk("press.num", numJogadas, refCount);
    chk("press.solta", dbEstado, 3);
    repeat (hold) tick();
    botoes = '0;
    tick();
    if (refCount == refLimit + 1) chkFlags("release.fim", 4, 0, 1, 0, 0);
    else                          chkFlags("release.espera", 1, 1, 0, 0, 0);
    repeat (gap) tick();
  endtask

  task automatic badPress(input logic [3:0] v);
    botoes = v;
    tick();
    chkFlags("bad", 14, 0, 0, 0, 1);
    chk("bad.num", numJogadas, refCount);
    botoes = '0;
    tick();
    chk("bad.hold", dbEstado, 14);
  endtask

  task automatic readAll();
    for (int a = 0; a < 16; a++) begin
      if (refValid[a]) begin
        endereco = 4'(a);
        tick();
        chk("read", dado, refMem[a]);
      end
    end
  endtask

  initial begin
    logic [3:0] v;
    int lim, badIdx;
    for (int i = 0; i < 16; i++) refValid[i] = 1'b0;

    // Reset state
    #2 reset = 1'b0;
    tick();
    tick();
    chkFlags("reset", 0, 0, 0, 0, 0);
    chk("reset.num", numJogadas, 0);
    chk("reset.dado", dado, 0);
    reset = 1'b1;
    botoes = 4'b0001;
    tick();
    chk("inicial.ignorePress", dbEstado, 0);
    botoes = '0;
    tick();

    // Three-move recording, limite=2
    iniciarT(2);
    pressMove(4'b0001, 1, 2);
    pressMove(4'b0100, 1, 2);
    pressMove(4'b1000, 1, 2);
    chk("seq3.num", numJogadas, 3);
    chkFlags("seq3", 4, 0, 1, 0, 0);
    readAll();

    // Timeout exactly 20 cycles after entering ESPERA
    iniciarT(3);
    pressMove(randOneHot(), 0, 0);
    repeat (19) tick();
    chkFlags("timeout.before", 1, 1, 0, 0, 0);
    tick();
    chkFlags("timeout", 14, 0, 0, 1, 0);
    chk("timeout.num", numJogadas, 1);

    // Press in the expiry cycle wins over the timeout
    iniciarT(3);
    repeat (19) tick();
    chk("race.stillEspera", dbEstado, 1);
    pressMove(randOneHot(), 1, 1);

    // Non-one-hot press: error, no write, count kept
    badPress(randMulti());
    readAll();
    iniciarT(3);

    // Long hold and change without release: one write only
    botoes = 4'b0010;
    repeat (10) tick();
    refMem[0] = 4'b0010; refValid[0] = 1'b1; refCount = 1;
    chk("hold.num", numJogadas, 1);
    chk("hold.solta", dbEstado, 3);
    botoes = 4'b0110;
    repeat (3) tick();
    chk("change.num", numJogadas, 1);
    chk("change.solta", dbEstado, 3);
    botoes = '0;
    tick();
    chk("hold.release", dbEstado, 1);
    readAll();

    // iniciar in REGISTRA abandons the write
    limite = 4'd1;
    botoes = 4'b1000;
    tick();
    chk("abandon.registra", dbEstado, 2);
    iniciar = 1'b1;
    botoes = '0;
    tick();
    iniciar = 1'b0;
    refCount = 0; refLimit = 1;
    chk("abandon.espera", dbEstado, 1);
    chk("abandon.num", numJogadas, 0);
    endereco = 4'd0;
    tick();
    chk("abandon.noWrite", dado, refMem[0]);

    // Bad press on the final move
    pressMove(4'b0100, 0, 1);
    badPress(randMulti());

    // Reset mid-SOLTA; RAM survives
    iniciarT(3);
    botoes = 4'b0001;
    tick();
    tick();
    refMem[0] = 4'b0001; refValid[0] = 1'b1;
    chk("midSolta", dbEstado, 3);
    #1 reset = 1'b0;
    #1;
    chkFlags("asyncReset", 0, 0, 0, 0, 0);
    chk("asyncReset.num", numJogadas, 0);
    chk("asyncReset.dado", dado, 0);
    botoes = '0;
    #1 reset = 1'b1;
    tick();
    readAll();

    // limite=F: 16 moves, then rerun starts at address 0
    iniciarT(15);
    for (int m = 0; m < 16; m++) pressMove(randOneHot(), $urandom_range(0, 2), $urandom_range(0, 2));
    chk("full.num", numJogadas, 16);
    chk("full.pronto", pronto, 1);
    readAll();
    iniciarT(0);
    v = (refMem[0] == 4'b0001) ? 4'b0010 : 4'b0001;
    pressMove(v, 0, 0);
    chk("wrap.num", numJogadas, 1);
    readAll();

    // Random rounds, some with an illegal press
    for (int r = 0; r < 8; r++) begin
      lim = $urandom_range(0, 6);
      badIdx = (r % 2 == 1) ? $urandom_range(0, lim) : 99;
      iniciarT(lim);
      for (int m = 0; m <= lim; m++) begin
        if (m == badIdx) begin
          badPress(randMulti());
          break;
        end
        pressMove(randOneHot(), $urandom_range(0, 3), $urandom_range(0, 3));
      end
      if (badIdx == 99) chk("round.num", numJogadas, lim + 1);
      else              chk("round.errNum", numJogadas, badIdx);
      readAll();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
